// File: rtl/ssd_pkg.sv
// Shared types and active-low segment patterns (bits a..g, a in the MSB) for
// the seven-segment scan reader.
package ssd_pkg;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_e;

  typedef struct packed {
    logic [3:0] code;
    logic       dp;
    logic       err;
  } digit_t;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0111000;
  localparam logic [6:0] SEG_B = 7'b0001000;
  localparam logic [6:0] SEG_C = 7'b1111001;
  localparam logic [6:0] SEG_D = 7'b1110001;
  localparam logic [6:0] SEG_E = 7'b1111110;
  localparam logic [6:0] SEG_F = 7'b1111111;

endpackage

// File: rtl/ssd_pattern_lookup.sv
// Combinational decode of one active-low segment byte into code, dp and an
// error flag for patterns outside the table.
module ssd_pattern_lookup
  import ssd_pkg::*;
(
  input  logic [7:0] pattern_i,
  output digit_t     digit_o
);

  always_comb begin
    digit_o.code = 4'hF;
    digit_o.dp   = ~pattern_i[0];
    digit_o.err  = 1'b0;
    case (pattern_i[7:1])
      SEG_0:   digit_o.code = 4'h0;
      SEG_1:   digit_o.code = 4'h1;
      SEG_2:   digit_o.code = 4'h2;
      SEG_3:   digit_o.code = 4'h3;
      SEG_4:   digit_o.code = 4'h4;
      SEG_5:   digit_o.code = 4'h5;
      SEG_6:   digit_o.code = 4'h6;
      SEG_7:   digit_o.code = 4'h7;
      SEG_8:   digit_o.code = 4'h8;
      SEG_9:   digit_o.code = 4'h9;
      SEG_A:   digit_o.code = 4'hA;
      SEG_B:   digit_o.code = 4'hB;
      SEG_C:   digit_o.code = 4'hC;
      SEG_D:   digit_o.code = 4'hD;
      SEG_E:   digit_o.code = 4'hE;
      SEG_F:   digit_o.code = 4'hF;
      default: digit_o.err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_reader.sv
// Samples a multiplexed active-low seven-segment bus, captures each digit once
// it has been stable, and presents complete frames on a valid/ready handshake.
module ssd_scan_reader
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              ssd,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   dp_flags,
  output logic [NUM_DIGITS-1:0]   err_flags,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [7:0]              r_ssd_q, p_ssd_q;
  logic [NUM_DIGITS-1:0]   r_an_q, p_an_q;
  digit_t                  dec_w, dec_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    captured_q, captured_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  digit_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] digit_val_q, digit_val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  state_e                  state_q, state_d;

  logic                    match, r_an_ok, p_an_ok, stable, capture, seen_full, load;
  logic [NUM_DIGITS-1:0]   cap_mask;

  ssd_pattern_lookup u_lookup (
    .pattern_i (r_ssd_q),
    .digit_o   (dec_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssd_q     <= '1;
      p_ssd_q     <= '1;
      r_an_q      <= '1;
      p_an_q      <= '1;
      dec_q       <= '0;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      seen_q      <= '0;
      shadow_q    <= '0;
      digit_val_q <= '0;
      dp_q        <= '0;
      err_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      state_q     <= COLLECT;
    end else begin
      r_ssd_q     <= ssd;
      p_ssd_q     <= r_ssd_q;
      r_an_q      <= an;
      p_an_q      <= r_an_q;
      dec_q       <= dec_w;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      seen_q      <= seen_d;
      shadow_q    <= shadow_d;
      digit_val_q <= digit_val_d;
      dp_q        <= dp_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    match   = (r_ssd_q == p_ssd_q) && (r_an_q == p_an_q);
    r_an_ok = $onehot(~r_an_q);
    p_an_ok = $onehot(~p_an_q);
    stable  = match && r_an_ok;

    // The capture reads the older sample (p_*/dec_q) so a dwell of exactly
    // STABLE_CYCLES pin samples is still captured after the pins move on.
    capture  = (cnt_q == CNT_MAX) && p_an_ok && !captured_q;
    cap_mask = capture ? ~p_an_q : '0;

    cnt_d      = stable ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1) : '0;
    captured_d = stable ? (captured_q | capture) : 1'b0;

    shadow_d = shadow_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (cap_mask[i]) shadow_d[i] = dec_q;
    end

    seen_full   = &seen_q;
    load        = 1'b0;
    state_d     = state_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    digit_val_d = digit_val_q;
    dp_d        = dp_q;
    err_d       = err_q;

    case (state_q)
      COLLECT: begin
        if (seen_full) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          if (seen_full) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = COLLECT;
          end
        end else if (seen_full) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (load) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        digit_val_d[4*i +: 4] = shadow_q[i].code;
        dp_d[i]               = shadow_q[i].dp;
        err_d[i]              = shadow_q[i].err;
      end
    end

    seen_d = (seen_full ? '0 : seen_q) | cap_mask;
  end

  assign digit_val   = digit_val_q;
  assign dp_flags    = dp_q;
  assign err_flags   = err_q;
  assign frame_valid = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/ssd_scan_reader.md
Name: ssd_scan_reader

Overview:
- Reads the other end of the seven-segment display interface.
- Samples a time-multiplexed, active-low segment bus (ssd) and anode bus (an), and converts each stable segment pattern back to a 4-bit code plus decimal-point flag.
- Assembles one code per digit into a complete display frame and hands the frame out on a valid/ready handshake.
- Used as an on-chip self-check of the display path and as a bench monitor for the reaction-timer display.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (an width), 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured, >=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ssd  in  8  segment bus, active-low; bit7=a, bit6=b … bit1=g, bit0=dp.
- an  in  NUM_DIGITS  digit select, active-low, one-hot-zero when valid.
- digit_val  out  4*NUM_DIGITS  captured codes; digit i in bits [4i+3:4i].
- dp_flags  out  NUM_DIGITS  1 = dp lit on digit i.
- err_flags  out  NUM_DIGITS  1 = digit i pattern not in decode table.
- frame_valid  out  1  frame outputs valid; held until accepted.
- frame_ready  in  1  consumer accepts the frame when frame_valid && frame_ready.
- overrun  out  1  sticky: a completed frame was dropped while one was pending.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; shadow regs, seen mask, stability counter and captured flag cleared; state COLLECT. Mid-operation reset discards the partial frame and any pending frame.
- Input stage: ssd and an registered once (r_ssd, r_an).
- Stability counter:
  - An is valid when ~r_an has exactly one bit set.
  - If r_ssd/r_an equal the previous registered sample and an is valid: counter increments, saturating at STABLE_CYCLES-1.
  - Otherwise: counter cleared and captured flag cleared.
- Capture:
  - Fires once per dwell, when counter==STABLE_CYCLES-1, an is valid and captured==0; then sets captured=1.
  - Writes shadow code, dp and err for index i = position of the 0 in r_an, and sets seen[i].
  - Latency: a pattern applied at the pins from edge E is captured at edge E+STABLE_CYCLES+1.
- Decode, on bits[7:1], active-low a..g:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - 0111000=A, 0001000=B, 1111001=C, 1110001=D, 1111110=E (dash), 1111111=F (blank).
  - Any other pattern: code F, err=1.
  - dp = ~bit0, valid for every code.
- FSM:
  - COLLECT: when seen is all-ones at a clock edge, copy shadow into digit_val/dp_flags/err_flags, set frame_valid, clear seen, go to HOLD. frame_valid rises one edge after the completing capture.
  - HOLD: captures continue into shadow/seen.
    - On handshake: frame_valid drops next edge, go to COLLECT.
    - If seen becomes all-ones without a handshake: set overrun, clear seen, drop the new frame; output regs unchanged.
    - Handshake and seen full in the same cycle: load the new frame, frame_valid stays 1, no overrun, stay in HOLD.
- A digit recaptured before the frame completes overwrites its shadow; the last capture wins.
- an all-ones (blanked) or multi-hot: no capture; the seen mask is retained.
- overrun clears only on reset.

Decomposition:
- Package ssd_pkg holds:
  - the 16 segment pattern constants (7-bit, active-low);
  - the FSM state typedef {COLLECT, HOLD};
  - the decoded-digit struct {code[3:0], dp, err}.
- Sub-module ssd_pattern_lookup: combinational 8-bit pattern -> {code, dp, err}, instantiated once on r_ssd.

Test Plan:
- Reset then scan NUM_DIGITS=4 with 1s dwell per digit, showing "1.234" (digit3 ssd=10011110, digits 2..0 = 00100101, 00001101, 10011001) -> frame_valid=1, digit_val=16'h1234, dp_flags=4'b1000, err_flags=0.
- Dwell of STABLE_CYCLES-1 identical cycles per digit -> no capture, frame_valid stays 0; same scan with STABLE_CYCLES dwell -> frame_valid rises one edge after digit0 capture.
- Hold frame_ready=0 through two full scans -> first frame retained, overrun=1 after the second scan; frame_ready=1 -> frame_valid=0 next edge.
- Inject illegal pattern 8'b01010101 on digit 2 -> digit_val[11:8]=4'hF, err_flags=4'b0100; blank 8'hFF on digit 1 -> code F, err=0.
- Multi-hot an=4'b0011 and an=4'b1111 for 20 cycles -> no seen bits set; rst_n pulsed low mid-scan -> all outputs 0 immediately, next full scan produces a correct frame.
- Frame completes in the same cycle as a frame_ready handshake -> new values loaded, frame_valid stays 1, overrun=0.
